// File: rtl/quadrature_generator_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Holds FSM encoding, direction codes and the index -> {A,B} lookup.
package quadrature_generator_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned POS_W_DEF      = 32;
    localparam int unsigned MIN_PHASE_CLKS = 2;
    localparam int unsigned IDX_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Bit order matches the decoder's direction bit.
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // {A,B} pair
    typedef logic [1:0] ab_t;

    // CW walks 00,10,11,01; CCW is the same walk with A and B swapped.
    function automatic ab_t quad_ab(input logic dir, input logic [IDX_W-1:0] idx);
        ab_t cw;
        case (idx)
            2'd0:    cw = 2'b00;
            2'd1:    cw = 2'b10;
            2'd2:    cw = 2'b11;
            default: cw = 2'b01;
        endcase
        return (dir == DIR_CW) ? cw : {cw[0], cw[1]};
    endfunction

endpackage

// File: rtl/quadrature_generator_if.sv
// Command handshake and waveform/status bundle of the quadrature generator.
// master = command source / observer, slave = generator.
interface quadrature_generator_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned POS_W = 32
) ();

    logic                    CMD_VALID;
    logic                    CMD_READY;
    logic                    CMD_DIR;
    logic [CNT_W-1:0]        CMD_STEPS;
    logic [CNT_W-1:0]        PHASE_CLKS;
    logic                    ABORT;
    logic                    SIG_A;
    logic                    SIG_B;
    logic                    BUSY;
    logic [1:0]              STEP_DONE;
    logic                    CMD_DONE;
    logic                    ABORTED;
    logic signed [POS_W-1:0] POSITION;

    modport master (
        output CMD_VALID, CMD_DIR, CMD_STEPS, PHASE_CLKS, ABORT,
        input  CMD_READY, SIG_A, SIG_B, BUSY, STEP_DONE, CMD_DONE, ABORTED, POSITION
    );

    modport slave (
        input  CMD_VALID, CMD_DIR, CMD_STEPS, PHASE_CLKS, ABORT,
        output CMD_READY, SIG_A, SIG_B, BUSY, STEP_DONE, CMD_DONE, ABORTED, POSITION
    );

endinterface

// File: rtl/quadrature_generator_quad_phase_timer.sv
// Loadable phase-dwell down-counter: ticks on the last clock of each dwell
// and reloads itself from the latched period so dwells repeat back to back.
module quad_phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tick_c
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            period_q <= CNT_W'(2);
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= load_val;
            cnt_q    <= load_val - CNT_W'(1);
        end else if (tick_c) begin
            cnt_q    <= period_q - CNT_W'(1);
        end else if (en) begin
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: turns a step command into registered A/B
// waveforms, one full 00->..->00 cycle per step, with position tracking.
module quadrature_generator
    import quadrature_generator_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned POS_W = POS_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    quadrature_generator_if.slave bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               abort_q, abort_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    ab_t                ab_q, ab_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [1:0]         step_done_q, step_done_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               timer_load_c;
    logic               tick_c;
    logic [CNT_W-1:0]   phase_clamped_c;

    // Decoder needs at least two clocks per A/B state.
    assign phase_clamped_c = (bus.PHASE_CLKS < CNT_W'(MIN_PHASE_CLKS))
                           ? CNT_W'(MIN_PHASE_CLKS) : bus.PHASE_CLKS;

    quad_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (timer_load_c),
        .load_val (phase_clamped_c),
        .en       (state_q == ST_RUN),
        .tick_c   (tick_c)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dir_q       <= DIR_CW;
            steps_q     <= '0;
            abort_q     <= 1'b0;
            pos_q       <= '0;
            ab_q        <= 2'b00;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            step_done_q <= 2'b00;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            steps_q     <= steps_d;
            abort_q     <= abort_d;
            pos_q       <= pos_d;
            ab_q        <= ab_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dir_d        = dir_q;
        steps_d      = steps_q;
        abort_d      = abort_q;
        pos_d        = pos_q;
        step_done_d  = 2'b00;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        timer_load_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.CMD_VALID && ready_q) begin
                    dir_d        = bus.CMD_DIR;
                    steps_d      = bus.CMD_STEPS;
                    abort_d      = 1'b0;
                    idx_d        = '0;
                    timer_load_c = 1'b1;
                    state_d      = (bus.CMD_STEPS == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.ABORT) begin
                    abort_d = 1'b1;
                end
                if (tick_c) begin
                    idx_d = idx_q + IDX_W'(1);
                    // A step completes only on the return to 00, so aborts wait for it.
                    if (idx_q == IDX_W'(3)) begin
                        step_done_d[dir_q] = 1'b1;
                        pos_d   = (dir_q == DIR_CW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        steps_d = steps_q - CNT_W'(1);
                        if (steps_q == CNT_W'(1) || abort_d) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_FINISH: begin
                done_d    = 1'b1;
                aborted_d = abort_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ab_d    = quad_ab(dir_d, idx_d);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign bus.SIG_A     = ab_q[1];
    assign bus.SIG_B     = ab_q[0];
    assign bus.CMD_READY = ready_q;
    assign bus.BUSY      = busy_q;
    assign bus.STEP_DONE = step_done_q;
    assign bus.CMD_DONE  = done_q;
    assign bus.ABORTED   = aborted_q;
    assign bus.POSITION  = pos_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: per-cycle waveform, pulse and
// handshake checks against hand-derived timing, plus an A/B loopback decoder.
module tb_quadrature_generator;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   fails  = 0;
    int   exp_pos = 0;
    int   cw_dec = 0, ccw_dec = 0, cw_sd = 0, ccw_sd = 0;
    logic [1:0] prev_ab = 2'b00;

    quadrature_generator_if #(.CNT_W(16), .POS_W(32)) bus ();

    quadrature_generator #(.CNT_W(16), .POS_W(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Loopback decoder: a step is counted on the closing transition into 00.
    always @(negedge CLK) begin
        if (prev_ab == 2'b01 && {bus.SIG_A, bus.SIG_B} == 2'b00) cw_dec++;
        if (prev_ab == 2'b10 && {bus.SIG_A, bus.SIG_B} == 2'b00) ccw_dec++;
        if (bus.STEP_DONE[0]) cw_sd++;
        if (bus.STEP_DONE[1]) ccw_sd++;
        prev_ab = {bus.SIG_A, bus.SIG_B};
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] lut(input logic dir, input int idx);
        logic [1:0] r;
        case ({dir, 2'(idx)})
            3'b000: r = 2'b00;
            3'b001: r = 2'b10;
            3'b010: r = 2'b11;
            3'b011: r = 2'b01;
            3'b100: r = 2'b00;
            3'b101: r = 2'b01;
            3'b110: r = 2'b11;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    task automatic start_cmd(input logic dir, input int steps, input int phase);
        int w;
        w = 0;
        while (!bus.CMD_READY && w < 1000) begin
            tick();
            w++;
        end
        chk("ready_wait", bus.CMD_READY, 1);
        bus.CMD_VALID  = 1'b1;
        bus.CMD_DIR    = dir;
        bus.CMD_STEPS  = 16'(steps);
        bus.PHASE_CLKS = 16'(phase);
        tick();
        bus.CMD_VALID  = 1'b0;
    endtask

    // Cycle c = cycles after the accepting edge; p = effective dwell, n = steps emitted.
    task automatic watch(input string tag, input logic dir, input int p, input int n,
                         input int abort_at, input int hold_at);
        int total;
        logic [1:0] e_ab;
        logic [1:0] e_sd;
        total = 4 * p * n + 1;
        for (int c = 1; c <= total; c++) begin
            tick();
            e_ab = (c < 4 * p * n) ? lut(dir, (c / p) % 4) : 2'b00;
            e_sd = (c % (4 * p) == 0 && c <= 4 * p * n) ? (dir ? 2'b10 : 2'b01) : 2'b00;
            chk({tag, "_ab"}, {bus.SIG_A, bus.SIG_B}, e_ab);
            chk({tag, "_step_done"}, bus.STEP_DONE, e_sd);
            chk({tag, "_cmd_done"}, bus.CMD_DONE, (c == total));
            chk({tag, "_ready"}, bus.CMD_READY, (c == total));
            chk({tag, "_busy"}, bus.BUSY, (c != total));
            if (c == abort_at) bus.ABORT = 1'b1;
            if (c == abort_at + 1) bus.ABORT = 1'b0;
            if (c == hold_at) begin
                bus.CMD_VALID  = 1'b1;
                bus.CMD_DIR    = 1'b1;
                bus.CMD_STEPS  = 16'd1;
                bus.PHASE_CLKS = 16'd3;
            end
        end
        chk({tag, "_aborted"}, bus.ABORTED, (abort_at != 0));
        exp_pos = dir ? exp_pos - n : exp_pos + n;
        chk({tag, "_position"}, 64'(bus.POSITION), 64'(exp_pos));
    endtask

    initial begin
        RST_N          = 1'b0;
        bus.CMD_VALID  = 1'b0;
        bus.CMD_DIR    = 1'b0;
        bus.CMD_STEPS  = '0;
        bus.PHASE_CLKS = '0;
        bus.ABORT      = 1'b0;
        tick();
        tick();
        chk("rst_ab", {bus.SIG_A, bus.SIG_B}, 2'b00);
        chk("rst_ready", bus.CMD_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_step_done", bus.STEP_DONE, 2'b00);
        chk("rst_cmd_done", bus.CMD_DONE, 0);
        chk("rst_aborted", bus.ABORTED, 0);
        chk("rst_position", 64'(bus.POSITION), 64'(0));
        RST_N = 1'b1;
        tick();

        // CW, 3 steps, 4 clk dwell: done at k+49, position 3
        start_cmd(1'b0, 3, 4);
        watch("t1", 1'b0, 4, 3, 0, 0);

        // CCW, 2 steps, 2 clk dwell: done at k+17, position 1
        start_cmd(1'b1, 2, 2);
        watch("t2", 1'b1, 2, 2, 0, 0);

        // Dwell 0 and 1 clamp to 2; zero steps finishes at k+1 with no edges
        start_cmd(1'b0, 1, 0);
        watch("t3a", 1'b0, 2, 1, 0, 0);
        start_cmd(1'b0, 1, 1);
        watch("t3b", 1'b0, 2, 1, 0, 0);
        start_cmd(1'b0, 0, 5);
        watch("t3c", 1'b0, 5, 0, 0, 0);

        // Abort during step 5 of 100 (cycles 49..60): step completes, then stop
        start_cmd(1'b0, 100, 3);
        watch("t4", 1'b0, 3, 5, 53, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_quiet_ab", {bus.SIG_A, bus.SIG_B}, 2'b00);
            chk("t4_quiet_busy", bus.BUSY, 0);
        end

        // Held VALID during RUN is ignored, then taken the cycle READY returns
        start_cmd(1'b0, 2, 2);
        watch("t5", 1'b0, 2, 2, 0, 5);
        tick();
        chk("t5_accept_busy", bus.BUSY, 1);
        chk("t5_accept_ready", bus.CMD_READY, 0);
        bus.CMD_VALID = 1'b0;
        watch("t5b", 1'b1, 3, 1, 0, 0);

        chk("loop_cw_vs_step_done", 64'(cw_dec), 64'(cw_sd));
        chk("loop_ccw_vs_step_done", 64'(ccw_dec), 64'(ccw_sd));
        chk("loop_cw_count", 64'(cw_dec), 64'(12));
        chk("loop_ccw_count", 64'(ccw_dec), 64'(3));

        // Reset mid-step while A = 1
        start_cmd(1'b0, 10, 4);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_pre_a", bus.SIG_A, 1);
        RST_N = 1'b0;
        tick();
        chk("t6_ab", {bus.SIG_A, bus.SIG_B}, 2'b00);
        chk("t6_position", 64'(bus.POSITION), 64'(0));
        chk("t6_ready", bus.CMD_READY, 1);
        chk("t6_busy", bus.BUSY, 0);
        RST_N = 1'b1;
        tick();
        tick();
        chk("t6_idle_ab", {bus.SIG_A, bus.SIG_B}, 2'b00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
